// File: rtl/s32x_sdr_arb_pkg.sv
// Shared types and constants for the 32X SDRAM arbiter between the master and slave SH-2.
package s32x_sdr_arb_pkg;

  typedef enum logic [1:0] {IDLE, REQ, BUSY, DONE} sdr_arb_state_t;

  typedef enum bit {REQ_M, REQ_S} sdr_req_id_t;

  localparam logic [15:0] SDR_TIMEOUT_DATA = 16'hFFFF;

  function automatic sdr_req_id_t sdr_other_id(input sdr_req_id_t id);
    return (id == REQ_M) ? REQ_S : REQ_M;
  endfunction

endpackage

// File: rtl/s32x_sdr_req.sv
// Per-CPU front end: stalls a CS3 bus cycle with WAIT and raises pending until it is served.
module s32x_sdr_req (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       ce_f,
  input  logic       cs_n,
  input  logic       bs_n,
  input  logic       rd_wr_n,
  input  logic       rd_n,
  input  logic [1:0] dqm_n,
  input  logic       granted,
  input  logic       gnt_done,
  output logic       stall,
  output logic       pending,
  output logic       is_read
);

  logic stall_q, stall_d;
  logic pend_q, pend_d;
  logic served_q, served_d;
  logic rd_q, rd_d;
  logic rd_strobe, wr_strobe;

  always_comb begin
    rd_strobe = rd_wr_n & ~rd_n;
    wr_strobe = ~rd_wr_n & (dqm_n != 2'b11);
    stall_d   = stall_q;
    pend_d    = pend_q;
    served_d  = served_q;
    rd_d      = rd_q;
    if (ce_f) begin
      if (cs_n) begin
        served_d = 1'b0;
        // An aborted cycle is only dropped while nothing has been started for it.
        if (!granted) begin
          stall_d = 1'b0;
          pend_d  = 1'b0;
        end
      end else if (!served_q) begin
        if (!bs_n) stall_d = 1'b1;
        if (!pend_q && (stall_q || !bs_n) && (rd_strobe || wr_strobe)) begin
          pend_d = 1'b1;
          rd_d   = rd_strobe;
        end
      end
    end
    if (gnt_done) begin
      stall_d  = 1'b0;
      pend_d   = 1'b0;
      served_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stall_q  <= 1'b0;
      pend_q   <= 1'b0;
      served_q <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      stall_q  <= stall_d;
      pend_q   <= pend_d;
      served_q <= served_d;
      rd_q     <= rd_d;
    end
  end

  assign stall   = stall_q;
  assign pending = pend_q;
  assign is_read = rd_q;

endmodule

// File: rtl/s32x_sdr_arb.sv
// Round-robin arbiter and sequencer sharing the single SDRAM port between both SH-2 CPUs.
module s32x_sdr_arb
  import s32x_sdr_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TOW     = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_F,
  input  logic        M_CS_N,
  input  logic        S_CS_N,
  input  logic        M_BS_N,
  input  logic        S_BS_N,
  input  logic        M_RD_WR_N,
  input  logic        S_RD_WR_N,
  input  logic        M_RD_N,
  input  logic        S_RD_N,
  input  logic [1:0]  M_DQM_N,
  input  logic [1:0]  S_DQM_N,
  input  logic [16:0] M_A,
  input  logic [16:0] S_A,
  input  logic [15:0] M_DI,
  input  logic [15:0] S_DI,
  output logic [15:0] M_DO,
  output logic [15:0] S_DO,
  output logic        M_WAIT,
  output logic        S_WAIT,
  output logic [16:0] SDR_A,
  output logic [15:0] SDR_DO,
  input  logic [15:0] SDR_DI,
  output logic        SDR_CS,
  output logic [1:0]  SDR_WE,
  output logic        SDR_RD,
  input  logic        SDR_WAIT
);

  // Last REQ cycle index; the counter holds REQ cycles already spent.
  localparam logic [TOW-1:0] TimeoutLast = TOW'(TIMEOUT - 1);

  sdr_arb_state_t state_q, state_d;
  sdr_req_id_t    gnt_q, gnt_d;
  sdr_req_id_t    last_gnt_q, last_gnt_d;
  logic [TOW-1:0] cnt_q, cnt_d;
  logic           ws_q;
  logic [16:0]    addr_q, addr_d;
  logic [15:0]    wdata_q, wdata_d;
  logic           rd_lat_q, rd_lat_d;
  logic [1:0]     we_lat_q, we_lat_d;
  logic           sdr_cs_q, sdr_cs_d;
  logic           sdr_rd_q, sdr_rd_d;
  logic [1:0]     sdr_we_q, sdr_we_d;
  logic [15:0]    m_do_q, m_do_d;
  logic [15:0]    s_do_q, s_do_d;
  logic           active_d;

  logic m_pend, s_pend, m_is_read, s_is_read, m_stall, s_stall;
  logic m_granted, s_granted, m_done, s_done;

  assign m_granted = (state_q != IDLE) && (gnt_q == REQ_M);
  assign s_granted = (state_q != IDLE) && (gnt_q == REQ_S);
  assign m_done    = (state_q == DONE) && (gnt_q == REQ_M);
  assign s_done    = (state_q == DONE) && (gnt_q == REQ_S);

  s32x_sdr_req u_req_m (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ce_f     (CE_F),
    .cs_n     (M_CS_N),
    .bs_n     (M_BS_N),
    .rd_wr_n  (M_RD_WR_N),
    .rd_n     (M_RD_N),
    .dqm_n    (M_DQM_N),
    .granted  (m_granted),
    .gnt_done (m_done),
    .stall    (m_stall),
    .pending  (m_pend),
    .is_read  (m_is_read)
  );

  s32x_sdr_req u_req_s (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .ce_f     (CE_F),
    .cs_n     (S_CS_N),
    .bs_n     (S_BS_N),
    .rd_wr_n  (S_RD_WR_N),
    .rd_n     (S_RD_N),
    .dqm_n    (S_DQM_N),
    .granted  (s_granted),
    .gnt_done (s_done),
    .stall    (s_stall),
    .pending  (s_pend),
    .is_read  (s_is_read)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_lat_d   = rd_lat_q;
    we_lat_d   = we_lat_q;
    m_do_d     = m_do_q;
    s_do_d     = s_do_q;
    unique case (state_q)
      IDLE: begin
        if (m_pend || s_pend) begin
          if (m_pend && s_pend) gnt_d = sdr_other_id(last_gnt_q);
          else                  gnt_d = m_pend ? REQ_M : REQ_S;
          if (gnt_d == REQ_M) begin
            addr_d   = M_A;
            wdata_d  = M_DI;
            rd_lat_d = m_is_read;
            we_lat_d = m_is_read ? 2'b00 : ~M_DQM_N;
          end else begin
            addr_d   = S_A;
            wdata_d  = S_DI;
            rd_lat_d = s_is_read;
            we_lat_d = s_is_read ? 2'b00 : ~S_DQM_N;
          end
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ws_q) begin
          state_d = BUSY;
        end else if (cnt_q >= TimeoutLast) begin
          state_d = DONE;
          if (rd_lat_q) begin
            if (gnt_q == REQ_M) m_do_d = SDR_TIMEOUT_DATA;
            else                s_do_d = SDR_TIMEOUT_DATA;
          end
        end else if (cnt_q != {TOW{1'b1}}) begin
          cnt_d = cnt_q + TOW'(1);
        end
      end
      BUSY: begin
        if (!ws_q) begin
          state_d = DONE;
          if (rd_lat_q) begin
            if (gnt_q == REQ_M) m_do_d = SDR_DI;
            else                s_do_d = SDR_DI;
          end
        end
      end
      DONE: begin
        last_gnt_d = gnt_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Strobes follow the next state so they rise together with the entry into REQ.
    active_d = (state_d == REQ) || (state_d == BUSY);
    sdr_cs_d = active_d;
    sdr_rd_d = active_d & rd_lat_d;
    sdr_we_d = active_d ? we_lat_d : 2'b00;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      gnt_q      <= REQ_M;
      last_gnt_q <= REQ_S;
      cnt_q      <= '0;
      ws_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_lat_q   <= 1'b0;
      we_lat_q   <= '0;
      sdr_cs_q   <= 1'b0;
      sdr_rd_q   <= 1'b0;
      sdr_we_q   <= '0;
      m_do_q     <= '0;
      s_do_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      ws_q       <= SDR_WAIT;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_lat_q   <= rd_lat_d;
      we_lat_q   <= we_lat_d;
      sdr_cs_q   <= sdr_cs_d;
      sdr_rd_q   <= sdr_rd_d;
      sdr_we_q   <= sdr_we_d;
      m_do_q     <= m_do_d;
      s_do_q     <= s_do_d;
    end
  end

  assign M_DO   = m_do_q;
  assign S_DO   = s_do_q;
  assign M_WAIT = m_stall;
  assign S_WAIT = s_stall;
  assign SDR_A  = addr_q;
  assign SDR_DO = wdata_q;
  assign SDR_CS = sdr_cs_q;
  assign SDR_RD = sdr_rd_q;
  assign SDR_WE = sdr_we_q;

endmodule
